pl_spi_slave_regs: RTL and testbench

SPI mode-0 responder with a byte-wide register file. It is the far end of the PL SPI master link, and lets PL logic act as an SPI peripheral: either an ADC-config emulator for closed-loop bench and board tests of the master, or a host-visible control register bank. All SPI pins are oversampled and synchronised into `i_Clk`, and the block does not use SCLK as a clock. Written registers are exposed to fabric through a write-strobe port and a combinational read port.

---
 rtl/pl_spi_slave_regs.sv | 246 ++++++++++++++++++++++++
 tb/tb_pl_spi_slave_regs.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pl_spi_slave_regs.sv
// SPI mode-0 responder with a byte-wide register file; all SPI pins are oversampled into i_Clk.
// Define PL_SPI_SLV_AUTOINC_EN to advance the register address after every data byte.
module pl_spi_slave_regs #(
    parameter int         DEPTH    = 32,
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_En,
    input  logic [6:0] i_Reg_Addr,
    output logic [7:0] o_Reg_Data,
    output logic       o_Wr_Strobe,
    output logic [6:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic [7:0] o_Byte_Cnt,
    output logic       o_Frame_Done,
    output logic       o_Frame_Err
);
    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] DEPTH_L = 8'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [2:0] sclk_sync_r;
    logic [2:0] cs_sync_r;
    logic [1:0] mosi_sync_r;
    logic [2:0] bit_cnt_r;
    logic [6:0] rx_shift_r;
    logic [6:0] addr_r;
    logic [7:0] miso_shift_r;
    logic       miso_bit_r;
    logic       miso_r;
    logic       miso_en_r;
    logic       wr_strobe_r;
    logic [6:0] wr_addr_r;
    logic [7:0] wr_data_r;
    logic [7:0] byte_cnt_r;
    logic       frame_done_r;
    logic       frame_err_r;
    logic [7:0] regs_r [DEPTH];

    logic       cs_low_s;
    logic       cs_fall_s;
    logic       cs_rise_s;
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       byte_end_s;
    logic [7:0] byte_s;
    logic [6:0] addr_next_s;
    logic [6:0] pre_addr_s;
    logic [7:0] pre_data_s;
    logic [7:0] fab_data_s;

    // Register is writable only inside the implemented range and never at the ID address.
    function automatic logic addr_writable(input logic [6:0] addr);
        return (addr != 7'd0) && ({1'b0, addr} < DEPTH_L);
    endfunction

    assign cs_low_s    = ~cs_sync_r[1];
    assign cs_fall_s   = cs_sync_r[2] & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_sync_r[2] & cs_sync_r[1];
    assign sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2] & cs_low_s;
    assign sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2] & cs_low_s;
    assign byte_s      = {rx_shift_r, mosi_sync_r[1]};
    assign byte_end_s  = sclk_rise_s && (bit_cnt_r == 3'd7) && (state_r != ST_IDLE);

`ifdef PL_SPI_SLV_AUTOINC_EN
    assign addr_next_s = addr_r + 7'd1;
`else
    assign addr_next_s = addr_r;
`endif

    assign pre_addr_s = (state_r == ST_CMD) ? byte_s[6:0] : addr_next_s;

    // Register-file read muxes for the MISO prefetch and the fabric port.
    always_comb begin
        pre_data_s = 8'h00;
        fab_data_s = 8'h00;
        if (pre_addr_s == 7'd0) begin
            pre_data_s = ID_VALUE;
        end else if ({1'b0, pre_addr_s} < DEPTH_L) begin
            pre_data_s = regs_r[pre_addr_s[AW-1:0]];
        end else begin
            pre_data_s = 8'h00;
        end
        if (i_Reg_Addr == 7'd0) begin
            fab_data_s = ID_VALUE;
        end else if ({1'b0, i_Reg_Addr} < DEPTH_L) begin
            fab_data_s = regs_r[i_Reg_Addr[AW-1:0]];
        end else begin
            fab_data_s = 8'h00;
        end
    end

    // Pin synchronisers; CS resets low so a reset inside a frame cannot fake a CS fall.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sclk_sync_r <= 3'b000;
            cs_sync_r   <= 3'b000;
            mosi_sync_r <= 2'b00;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], i_SPI_Clk};
            cs_sync_r   <= {cs_sync_r[1:0], i_SPI_CS};
            mosi_sync_r <= {mosi_sync_r[0], i_SPI_MOSI};
        end
    end

    // Frame state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_s = ST_CMD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (cs_rise_s) begin
                    state_s = ST_IDLE;
                end else if (byte_end_s) begin
                    state_s = byte_s[7] ? ST_RDATA : ST_WDATA;
                end else begin
                    state_s = ST_CMD;
                end
            end
            ST_WDATA, ST_RDATA: begin
                if (cs_rise_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Shift datapath, register file, counters and registered outputs.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            bit_cnt_r    <= 3'd0;
            rx_shift_r   <= 7'd0;
            addr_r       <= 7'd0;
            miso_shift_r <= 8'h00;
            miso_bit_r   <= 1'b0;
            miso_r       <= 1'b0;
            miso_en_r    <= 1'b0;
            wr_strobe_r  <= 1'b0;
            wr_addr_r    <= 7'd0;
            wr_data_r    <= 8'h00;
            byte_cnt_r   <= 8'h00;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else begin
            wr_strobe_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (state_r == ST_IDLE) begin
                if (cs_fall_s) begin
                    bit_cnt_r    <= 3'd0;
                    rx_shift_r   <= 7'd0;
                    miso_shift_r <= 8'h00;
                    miso_bit_r   <= 1'b0;
                    byte_cnt_r   <= 8'h00;
                end
            end else if (cs_rise_s) begin
                frame_done_r <= 1'b1;
                frame_err_r  <= (bit_cnt_r != 3'd0);
            end else begin
                if (sclk_rise_s) begin
                    bit_cnt_r  <= bit_cnt_r + 3'd1;
                    rx_shift_r <= byte_s[6:0];
                end
                if (byte_end_s) begin
                    if (byte_cnt_r != 8'hFF) begin
                        byte_cnt_r <= byte_cnt_r + 8'd1;
                    end
                    case (state_r)
                        ST_CMD: begin
                            addr_r <= byte_s[6:0];
                            if (byte_s[7]) begin
                                miso_shift_r <= pre_data_s;
                            end
                        end
                        ST_WDATA: begin
                            if (addr_writable(addr_r)) begin
                                regs_r[addr_r[AW-1:0]] <= byte_s;
                                wr_strobe_r <= 1'b1;
                                wr_addr_r   <= addr_r;
                                wr_data_r   <= byte_s;
                            end
                            addr_r <= addr_next_s;
                        end
                        ST_RDATA: begin
                            miso_shift_r <= pre_data_s;
                            addr_r       <= addr_next_s;
                        end
                        default: begin
                            addr_r <= addr_r;
                        end
                    endcase
                end else if (sclk_fall_s) begin
                    miso_bit_r   <= miso_shift_r[7];
                    miso_shift_r <= {miso_shift_r[6:0], 1'b0};
                end
            end
            miso_en_r <= cs_low_s && (state_r != ST_IDLE);
            miso_r    <= (cs_low_s && (state_r != ST_IDLE)) ? miso_bit_r : 1'b0;
        end
    end

    assign o_SPI_MISO    = miso_r;
    assign o_SPI_MISO_En = miso_en_r;
    assign o_Reg_Data    = fab_data_s;
    assign o_Wr_Strobe   = wr_strobe_r;
    assign o_Wr_Addr     = wr_addr_r;
    assign o_Wr_Data     = wr_data_r;
    assign o_Byte_Cnt    = byte_cnt_r;
    assign o_Frame_Done  = frame_done_r;
    assign o_Frame_Err   = frame_err_r;

endmodule

// File: tb/tb_pl_spi_slave_regs.sv
// Directed bench for pl_spi_slave_regs: bit-banged SPI mode-0 frames with hand-computed expectations.
module tb_pl_spi_slave_regs;
    localparam int HB = 9;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic       i_SPI_Clk = 1'b0;
    logic       i_SPI_CS = 1'b1;
    logic       i_SPI_MOSI = 1'b0;
    logic       o_SPI_MISO;
    logic       o_SPI_MISO_En;
    logic [6:0] i_Reg_Addr = 7'd0;
    logic [7:0] o_Reg_Data;
    logic       o_Wr_Strobe;
    logic [6:0] o_Wr_Addr;
    logic [7:0] o_Wr_Data;
    logic [7:0] o_Byte_Cnt;
    logic       o_Frame_Done;
    logic       o_Frame_Err;

    int checks = 0;
    int failures = 0;

    int         strobe_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;
    logic [6:0] last_addr = 7'd0;
    logic [7:0] last_data = 8'h00;

    pl_spi_slave_regs dut (
        .i_Clk        (i_Clk),
        .i_Rst        (i_Rst),
        .i_SPI_Clk    (i_SPI_Clk),
        .i_SPI_CS     (i_SPI_CS),
        .i_SPI_MOSI   (i_SPI_MOSI),
        .o_SPI_MISO   (o_SPI_MISO),
        .o_SPI_MISO_En(o_SPI_MISO_En),
        .i_Reg_Addr   (i_Reg_Addr),
        .o_Reg_Data   (o_Reg_Data),
        .o_Wr_Strobe  (o_Wr_Strobe),
        .o_Wr_Addr    (o_Wr_Addr),
        .o_Wr_Data    (o_Wr_Data),
        .o_Byte_Cnt   (o_Byte_Cnt),
        .o_Frame_Done (o_Frame_Done),
        .o_Frame_Err  (o_Frame_Err)
    );

    always #5 i_Clk = ~i_Clk;

    // Event monitor for the single-cycle pulses.
    always @(negedge i_Clk) begin
        if (o_Wr_Strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_addr  = o_Wr_Addr;
            last_data  = o_Wr_Data;
        end
        if (o_Frame_Done) done_cnt = done_cnt + 1;
        if (o_Frame_Err) err_cnt = err_cnt + 1;
    end

    task automatic cs_begin();
        i_SPI_CS = 1'b0;
        repeat (HB) @(negedge i_Clk);
    endtask

    task automatic cs_end();
        repeat (HB) @(negedge i_Clk);
        i_SPI_CS = 1'b1;
        repeat (10) @(negedge i_Clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            i_SPI_MOSI = tx[i];
            repeat (HB) @(negedge i_Clk);
            i_SPI_Clk = 1'b1;
            rx[i] = o_SPI_MISO;
            repeat (HB) @(negedge i_Clk);
            i_SPI_Clk = 1'b0;
        end
    endtask

    task automatic frame2(input logic [7:0] b0, input logic [7:0] b1,
                          output logic [7:0] r0, output logic [7:0] r1);
        cs_begin();
        spi_bits(b0, 8, r0);
        spi_bits(b1, 8, r1);
        cs_end();
    endtask

    task automatic read_fab(input logic [6:0] a, output logic [7:0] d);
        i_Reg_Addr = a;
        #1;
        d = o_Reg_Data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        checks++; if (o_Wr_Strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", o_Wr_Strobe); end
        checks++; if (o_SPI_MISO_En !== 1'b0 || o_SPI_MISO !== 1'b0) begin failures++; $display("FAIL reset_miso got en=%b miso=%b exp 0/0", o_SPI_MISO_En, o_SPI_MISO); end
        checks++; if (o_Byte_Cnt !== 8'h00) begin failures++; $display("FAIL reset_bytecnt got=%h exp=00", o_Byte_Cnt); end
        checks++; if (o_Frame_Done !== 1'b0 || o_Frame_Err !== 1'b0) begin failures++; $display("FAIL reset_frame got done=%b err=%b exp 0/0", o_Frame_Done, o_Frame_Err); end
        read_fab(7'd0, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL reset_id got=%h exp=a5", d); end
        read_fab(7'd5, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg5 got=%h exp=00", d); end
    endtask

    task automatic test_write();
        logic [7:0] r0, r1, d;
        int s0, dn0, e0;
        s0 = strobe_cnt; dn0 = done_cnt; e0 = err_cnt;
        frame2(8'h05, 8'h3C, r0, r1);
        checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL wr_strobes got=%0d exp=1", strobe_cnt - s0); end
        checks++; if (last_addr !== 7'h05 || last_data !== 8'h3C) begin failures++; $display("FAIL wr_addr_data got=%h/%h exp=05/3c", last_addr, last_data); end
        read_fab(7'd5, d);
        checks++; if (d !== 8'h3C) begin failures++; $display("FAIL wr_reg5 got=%h exp=3c", d); end
        checks++; if (o_Byte_Cnt !== 8'd2) begin failures++; $display("FAIL wr_bytecnt got=%0d exp=2", o_Byte_Cnt); end
        checks++; if (done_cnt - dn0 !== 1 || err_cnt - e0 !== 0) begin failures++; $display("FAIL wr_frame got done=%0d err=%0d exp 1/0", done_cnt - dn0, err_cnt - e0); end
    endtask

    task automatic test_read();
        logic [7:0] r0, r1, r2, r3;
        int s0;
        s0 = strobe_cnt;
        frame2(8'h80, 8'h00, r0, r1);
        checks++; if (r0 !== 8'h00 || r1 !== 8'hA5) begin failures++; $display("FAIL rd_id got=%h/%h exp=00/a5", r0, r1); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL rd_nostrobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (o_SPI_MISO_En !== 1'b0 || o_SPI_MISO !== 1'b0) begin failures++; $display("FAIL rd_idle_miso got en=%b miso=%b exp 0/0", o_SPI_MISO_En, o_SPI_MISO); end
        cs_begin();
        checks++; if (o_SPI_MISO_En !== 1'b1) begin failures++; $display("FAIL rd_en_active got=%b exp=1", o_SPI_MISO_En); end
        spi_bits(8'h85, 8, r0);
        spi_bits(8'hFF, 8, r1);
        spi_bits(8'h00, 8, r2);
        spi_bits(8'h00, 8, r3);
        cs_end();
`ifdef PL_SPI_SLV_AUTOINC_EN
        checks++; if (r1 !== 8'h3C || r2 !== 8'h00 || r3 !== 8'h00) begin failures++; $display("FAIL rd_burst got=%h/%h/%h exp=3c/00/00", r1, r2, r3); end
`else
        checks++; if (r1 !== 8'h3C || r2 !== 8'h3C || r3 !== 8'h3C) begin failures++; $display("FAIL rd_burst got=%h/%h/%h exp=3c/3c/3c", r1, r2, r3); end
`endif
        checks++; if (o_Byte_Cnt !== 8'd4) begin failures++; $display("FAIL rd_bytecnt got=%0d exp=4", o_Byte_Cnt); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL rd_mosi_ignored got=%0d exp=0", strobe_cnt - s0); end
    endtask

    task automatic test_burst();
        logic [7:0] r0, d;
        int s0;
        s0 = strobe_cnt;
        cs_begin();
        spi_bits(8'h1F, 8, r0);
        spi_bits(8'h11, 8, r0);
        spi_bits(8'h22, 8, r0);
        cs_end();
        read_fab(7'd31, d);
`ifdef PL_SPI_SLV_AUTOINC_EN
        checks++; if (d !== 8'h11) begin failures++; $display("FAIL burst_reg31 got=%h exp=11", d); end
        checks++; if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL burst_strobes got=%0d exp=1", strobe_cnt - s0); end
`else
        checks++; if (d !== 8'h22) begin failures++; $display("FAIL burst_reg31 got=%h exp=22", d); end
        checks++; if (strobe_cnt - s0 !== 2) begin failures++; $display("FAIL burst_strobes got=%0d exp=2", strobe_cnt - s0); end
`endif
        read_fab(7'd0, d);
        checks++; if (d !== 8'hA5) begin failures++; $display("FAIL burst_reg0 got=%h exp=a5", d); end
        checks++; if (o_Byte_Cnt !== 8'd3) begin failures++; $display("FAIL burst_bytecnt got=%0d exp=3", o_Byte_Cnt); end
    endtask

    task automatic test_out_of_range();
        logic [7:0] r0, r1, d;
        int s0;
        s0 = strobe_cnt;
        frame2(8'h40, 8'h77, r0, r1);
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL oor_strobe got=%0d exp=0", strobe_cnt - s0); end
        frame2(8'hC0, 8'h00, r0, r1);
        checks++; if (r1 !== 8'h00) begin failures++; $display("FAIL oor_read got=%h exp=00", r1); end
        read_fab(7'h40, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL oor_fabric got=%h exp=00", d); end
        frame2(8'h00, 8'h5A, r0, r1);
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL wr_addr0_strobe got=%0d exp=0", strobe_cnt - s0); end
    endtask

    task automatic test_partial();
        logic [7:0] r0, d;
        int s0, dn0, e0;
        s0 = strobe_cnt; dn0 = done_cnt; e0 = err_cnt;
        cs_begin();
        spi_bits(8'h06, 8, r0);
        spi_bits(8'hE7, 4, r0);
        cs_end();
        checks++; if (err_cnt - e0 !== 1 || done_cnt - dn0 !== 1) begin failures++; $display("FAIL partial_err got err=%0d done=%0d exp 1/1", err_cnt - e0, done_cnt - dn0); end
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL partial_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (o_Byte_Cnt !== 8'd1) begin failures++; $display("FAIL partial_bytecnt got=%0d exp=1", o_Byte_Cnt); end
        read_fab(7'd6, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL partial_reg6 got=%h exp=00", d); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r0, r1, d;
        int s0;
        s0 = strobe_cnt;
        cs_begin();
        spi_bits(8'h07, 8, r0);
        spi_bits(8'h5A, 1, r0);
        i_SPI_MOSI = 1'b1;
        repeat (3) @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (5) @(negedge i_Clk);
        read_fab(7'd5, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_reg5 got=%h exp=00", d); end
        read_fab(7'd31, d);
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL rstmid_reg31 got=%h exp=00", d); end
        checks++; if (o_SPI_MISO_En !== 1'b0) begin failures++; $display("FAIL rstmid_en got=%b exp=0", o_SPI_MISO_En); end
        spi_bits(8'hB4, 7, r0);
        cs_end();
        checks++; if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL rstmid_strobe got=%0d exp=0", strobe_cnt - s0); end
        checks++; if (o_Byte_Cnt !== 8'd0) begin failures++; $display("FAIL rstmid_bytecnt got=%0d exp=0", o_Byte_Cnt); end
        frame2(8'h07, 8'h5A, r0, r1);
        checks++; if (strobe_cnt - s0 !== 1 || last_addr !== 7'h07 || last_data !== 8'h5A) begin failures++; $display("FAIL rstmid_recover got n=%0d %h/%h exp 1 07/5a", strobe_cnt - s0, last_addr, last_data); end
        read_fab(7'd7, d);
        checks++; if (d !== 8'h5A) begin failures++; $display("FAIL rstmid_reg7 got=%h exp=5a", d); end
    endtask

    initial begin
        repeat (4) @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (4) @(negedge i_Clk);
        test_reset();
        test_write();
        test_read();
        test_burst();
        test_out_of_range();
        test_partial();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
